// File: rtl/nasti_dma_sequencer_if.sv
// Descriptor, mover and completion signals of the DMA sequencer.
// master: sequencer side; slave: descriptor source, mover and completion sink.
interface nasti_dma_sequencer_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_WIDTH-1:0] desc_src;
  logic [ADDR_WIDTH-1:0] desc_dest;
  logic [ADDR_WIDTH-1:0] desc_len;

  logic [ADDR_WIDTH-1:0] mover_src_addr;
  logic [ADDR_WIDTH-1:0] mover_dest_addr;
  logic [ADDR_WIDTH-1:0] mover_length;
  logic                  mover_en;
  logic                  mover_done;

  logic                  cmpl_valid;
  logic                  cmpl_ready;
  logic [7:0]            cmpl_tag;
  logic                  cmpl_err;

  modport master (
    input  desc_valid, desc_src, desc_dest, desc_len,
    output desc_ready,
    output mover_src_addr, mover_dest_addr, mover_length, mover_en,
    input  mover_done,
    output cmpl_valid, cmpl_tag, cmpl_err,
    input  cmpl_ready
  );

  modport slave (
    output desc_valid, desc_src, desc_dest, desc_len,
    input  desc_ready,
    input  mover_src_addr, mover_dest_addr, mover_length, mover_en,
    output mover_done,
    input  cmpl_valid, cmpl_tag, cmpl_err,
    output cmpl_ready
  );
endinterface

// File: rtl/nasti_dma_sequencer.sv
// Descriptor FIFO + sequencer feeding nasti_data_mover, one completion per desc.
// Ports: aclk, areset (sync, high), bus (master modport), busy, pending.
module nasti_dma_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  nasti_dma_sequencer_if.master  bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LEN_MASK =
    ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    CMPL
  } state_t;

  logic [ADDR_WIDTH-1:0] mem_src  [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_dest [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_len  [DEPTH];
  logic [7:0]            mem_tag  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    tag_cnt;

  logic push;
  logic pop;
  logic h_ok;

  logic [ADDR_WIDTH-1:0] h_src;
  logic [ADDR_WIDTH-1:0] h_dest;
  logic [ADDR_WIDTH-1:0] h_len;
  logic [7:0]            h_tag;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  en_q, en_d;
  logic                  cvalid_q, cvalid_d;
  logic [7:0]            tag_q, tag_d;
  logic                  err_q, err_d;

  assign bus.desc_ready = (count != FULL);
  assign push = bus.desc_valid && bus.desc_ready;
  assign pop  = (state_q == IDLE) && (count != '0);

  assign h_src  = mem_src[rd_ptr];
  assign h_dest = mem_dest[rd_ptr];
  assign h_len  = mem_len[rd_ptr];
  assign h_tag  = mem_tag[rd_ptr];
  assign h_ok   = (h_len != '0) && ((h_len & LEN_MASK) == '0);

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_src[wr_ptr]  <= bus.desc_src;
      mem_dest[wr_ptr] <= bus.desc_dest;
      mem_len[wr_ptr]  <= bus.desc_len;
      mem_tag[wr_ptr]  <= tag_cnt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        tag_cnt <= tag_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dest_d   = dest_q;
    len_d    = len_q;
    en_d     = 1'b0;
    cvalid_d = cvalid_q;
    tag_d    = tag_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          src_d  = h_src;
          dest_d = h_dest;
          len_d  = h_len;
          tag_d  = h_tag;
          if (h_ok) begin
            state_d = ISSUE;
            err_d   = 1'b0;
            // en is registered: decide it from done one cycle ahead
            en_d    = bus.mover_done;
          end else begin
            state_d  = CMPL;
            err_d    = 1'b1;
            cvalid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (en_q) begin
          state_d = WAIT_START;
        end else begin
          en_d = bus.mover_done;
        end
      end
      WAIT_START: begin
        if (!bus.mover_done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.mover_done) begin
          state_d  = CMPL;
          cvalid_d = 1'b1;
          err_d    = 1'b0;
        end
      end
      CMPL: begin
        if (bus.cmpl_ready) begin
          state_d  = IDLE;
          cvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dest_q   <= '0;
      len_q    <= '0;
      en_q     <= 1'b0;
      cvalid_q <= 1'b0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      len_q    <= len_d;
      en_q     <= en_d;
      cvalid_q <= cvalid_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
  end

  assign bus.mover_src_addr  = src_q;
  assign bus.mover_dest_addr = dest_q;
  assign bus.mover_length    = len_q;
  assign bus.mover_en        = en_q;
  assign bus.cmpl_valid      = cvalid_q;
  assign bus.cmpl_tag        = tag_q;
  assign bus.cmpl_err        = err_q;

  assign busy    = (state_q != IDLE) || (count != '0);
  assign pending = count;

endmodule

// File: tb/tb_nasti_dma_sequencer.sv
// Directed bench for nasti_dma_sequencer with a simple mover model.
// Mover drops done for mv_lat cycles after each en pulse.
module tb_nasti_dma_sequencer;

  localparam int AW = 64;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       busy;
  logic [2:0] pending;

  nasti_dma_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  nasti_dma_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(64),
    .DEPTH(4)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus),
    .busy(busy),
    .pending(pending)
  );

  always #5 aclk = ~aclk;

  int tests_run = 0;
  int tests_failed = 0;

  logic mv_done_r = 1'b1;
  logic mv_hold = 1'b0;
  int   mv_cnt = 0;
  int   mv_lat = 3;

  assign bus.mover_done = mv_done_r & ~mv_hold;

  always @(posedge aclk) begin
    if (bus.mover_en) begin
      mv_cnt    <= mv_lat;
      mv_done_r <= 1'b0;
    end else if (mv_cnt != 0) begin
      mv_cnt <= mv_cnt - 1;
      if (mv_cnt == 1) mv_done_r <= 1'b1;
    end
  end

  int         en_cnt = 0;
  int         en_dbl = 0;
  int         stab_err = 0;
  logic       en_prev = 1'b0;
  logic       in_xfer = 1'b0;
  logic [63:0] cap_src, cap_dest, cap_len;
  logic [8:0] cq[$];

  always @(negedge aclk) begin
    if (bus.mover_en) en_cnt++;
    if (bus.mover_en && en_prev) en_dbl++;
    en_prev = bus.mover_en;
    if (bus.cmpl_valid && bus.cmpl_ready)
      cq.push_back({bus.cmpl_err, bus.cmpl_tag});
    if (areset) begin
      in_xfer = 1'b0;
    end else if (bus.mover_en) begin
      in_xfer  = 1'b1;
      cap_src  = bus.mover_src_addr;
      cap_dest = bus.mover_dest_addr;
      cap_len  = bus.mover_length;
    end else if (in_xfer) begin
      if (bus.cmpl_valid) in_xfer = 1'b0;
      else if (bus.mover_length !== cap_len ||
               bus.mover_src_addr !== cap_src ||
               bus.mover_dest_addr !== cap_dest)
        stab_err++;
    end
  end

  task automatic do_reset();
    for (int i = 0; i < 200 && !mv_done_r; i++) @(posedge aclk);
    @(posedge aclk); #1;
    areset = 1'b1;
    bus.desc_valid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic drive_desc(input logic [63:0] s, d, l);
    bus.desc_src   = s;
    bus.desc_dest  = d;
    bus.desc_len   = l;
    bus.desc_valid = 1'b1;
  endtask

  task automatic wait_accept(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge aclk);
      if (bus.desc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic wait_cmpl(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run += 9;
    if (bus.desc_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_ready got %b want 1", bus.desc_ready);
    end
    if (bus.mover_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_en got %b want 0", bus.mover_en);
    end
    if (bus.mover_src_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL rst_src got %h want 0", bus.mover_src_addr);
    end
    if (bus.mover_dest_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL rst_dest got %h want 0", bus.mover_dest_addr);
    end
    if (bus.mover_length !== 64'h0) begin
      tests_failed++;
      $display("FAIL rst_len got %h want 0", bus.mover_length);
    end
    if (bus.cmpl_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_cvalid got %b want 0", bus.cmpl_valid);
    end
    if ({bus.cmpl_err, bus.cmpl_tag} !== 9'h0) begin
      tests_failed++;
      $display("FAIL rst_tagerr got %h want 0",
               {bus.cmpl_err, bus.cmpl_tag});
    end
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    if (pending !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_pending got %0d want 0", pending);
    end
  endtask

  task automatic test_single();
    int e0, q0;
    bit ok;
    do_reset();
    bus.cmpl_ready = 1'b1;
    mv_lat = 3;
    e0 = en_cnt;
    q0 = cq.size();
    drive_desc(64'h1000, 64'h2000, 64'h40);
    @(negedge aclk);
    tests_run++;
    if (bus.desc_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready got %b want 1", bus.desc_ready);
    end
    @(posedge aclk); #1;
    bus.desc_valid = 1'b0;
    @(negedge aclk);
    tests_run++;
    if (bus.mover_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_en_n1 got %b want 0", bus.mover_en);
    end
    @(negedge aclk);
    tests_run++;
    if ({bus.mover_en, bus.mover_src_addr, bus.mover_dest_addr,
         bus.mover_length} !== {1'b1, 64'h1000, 64'h2000, 64'h40}) begin
      tests_failed++;
      $display("FAIL single_issue_n2 got en=%b %h %h %h want 1 1000 2000 40",
               bus.mover_en, bus.mover_src_addr, bus.mover_dest_addr,
               bus.mover_length);
    end
    @(negedge aclk);
    tests_run++;
    if (bus.mover_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_en_n3 got %b want 0", bus.mover_en);
    end
    wait_cmpl(q0 + 1, 100, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL single_cmpl_timeout got none want 1 completion");
    end else if (cq[q0] !== 9'h000) begin
      tests_failed++;
      $display("FAIL single_cmpl got %h want 000", cq[q0]);
    end
    tests_run++;
    if (en_cnt - e0 !== 1) begin
      tests_failed++;
      $display("FAIL single_en_count got %0d want 1", en_cnt - e0);
    end
  endtask

  task automatic test_fifo_fill();
    int q0, waited, ready_bad, max_pend;
    bit ok, saw_full;
    do_reset();
    bus.cmpl_ready = 1'b1;
    mv_lat = 2;
    mv_hold = 1'b1;
    q0 = cq.size();
    ready_bad = 0;
    max_pend = 0;
    saw_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_desc(64'(k) << 12, 64'h8000 + (64'(k) << 12),
                 64'h40 * 64'(k + 1));
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge aclk);
        if (int'(pending) > max_pend) max_pend = int'(pending);
        if (bus.desc_ready !== (pending != 3'd4)) ready_bad++;
        if (pending == 3'd4 && !bus.desc_ready) saw_full = 1'b1;
        if (bus.desc_ready) begin
          ok = 1'b1;
          break;
        end
        waited++;
        if (waited == 10) mv_hold = 1'b0;
      end
      @(posedge aclk); #1;
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL fill_accept%0d got timeout want accept", k);
      end
    end
    bus.desc_valid = 1'b0;
    mv_hold = 1'b0;
    tests_run += 3;
    if (max_pend > 4) begin
      tests_failed++;
      $display("FAIL fill_max_pending got %0d want <=4", max_pend);
    end
    if (ready_bad !== 0) begin
      tests_failed++;
      $display("FAIL fill_ready_vs_pending got %0d bad want 0", ready_bad);
    end
    if (!saw_full) begin
      tests_failed++;
      $display("FAIL fill_full got no stall want ready low at 4");
    end
    wait_cmpl(q0 + 6, 500, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fill_cmpl_timeout got %0d want 6", cq.size() - q0);
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests_run++;
        if (cq[q0 + k] !== {1'b0, 8'(k)}) begin
          tests_failed++;
          $display("FAIL fill_tag%0d got %h want %h",
                   k, cq[q0 + k], {1'b0, 8'(k)});
        end
      end
    end
  endtask

  task automatic test_invalid();
    int e0, q0;
    bit ok;
    logic [63:0] bad_len [2];
    bad_len[0] = 64'h0;
    bad_len[1] = 64'h44;
    do_reset();
    bus.cmpl_ready = 1'b1;
    mv_lat = 2;
    e0 = en_cnt;
    q0 = cq.size();
    for (int k = 0; k < 2; k++) begin
      drive_desc(64'h3000, 64'h4000, bad_len[k]);
      @(negedge aclk);
      @(posedge aclk); #1;
      bus.desc_valid = 1'b0;
      @(negedge aclk);
      tests_run++;
      if (bus.cmpl_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL inv%0d_n1 got cvalid=%b want 0", k, bus.cmpl_valid);
      end
      @(negedge aclk);
      tests_run++;
      if ({bus.cmpl_valid, bus.cmpl_err, bus.cmpl_tag} !==
          {1'b1, 1'b1, 8'(k)}) begin
        tests_failed++;
        $display("FAIL inv%0d_n2 got v=%b e=%b t=%0d want 1 1 %0d",
                 k, bus.cmpl_valid, bus.cmpl_err, bus.cmpl_tag, k);
      end
      @(posedge aclk); #1;
    end
    drive_desc(64'h3000, 64'h4000, 64'h80);
    wait_accept(20, ok);
    bus.desc_valid = 1'b0;
    wait_cmpl(q0 + 3, 100, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL inv_cmpl_timeout got %0d want 3", cq.size() - q0);
    end else if (cq[q0 + 2] !== 9'h002) begin
      tests_failed++;
      $display("FAIL inv_third got %h want 002", cq[q0 + 2]);
    end
    tests_run++;
    if (en_cnt - e0 !== 1) begin
      tests_failed++;
      $display("FAIL inv_en_count got %0d want 1", en_cnt - e0);
    end
  endtask

  task automatic test_backpressure();
    int q0, e1, bad;
    bit ok;
    logic [7:0] t0;
    logic       r0;
    do_reset();
    bus.cmpl_ready = 1'b0;
    mv_lat = 2;
    q0 = cq.size();
    drive_desc(64'h100, 64'h200, 64'h40);
    wait_accept(20, ok);
    drive_desc(64'h300, 64'h400, 64'h80);
    wait_accept(20, ok);
    bus.desc_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.cmpl_valid) begin
        ok = 1'b1;
        break;
      end
    end
    t0 = bus.cmpl_tag;
    r0 = bus.cmpl_err;
    #1;
    e1 = en_cnt;
    tests_run++;
    if (!ok || {r0, t0} !== 9'h000) begin
      tests_failed++;
      $display("FAIL bp_first got ok=%b %h want 1 000", ok, {r0, t0});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (!bus.cmpl_valid || bus.cmpl_tag !== t0 || bus.cmpl_err !== r0)
        bad++;
    end
    #1;
    tests_run += 3;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_stable got %0d bad cycles want 0", bad);
    end
    if (en_cnt !== e1) begin
      tests_failed++;
      $display("FAIL bp_no_en got %0d want %0d", en_cnt, e1);
    end
    if (pending !== 3'd1) begin
      tests_failed++;
      $display("FAIL bp_pending got %0d want 1", pending);
    end
    @(posedge aclk); #1;
    bus.cmpl_ready = 1'b1;
    @(negedge aclk);
    tests_run++;
    if (bus.cmpl_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_hs got %b want 1", bus.cmpl_valid);
    end
    @(negedge aclk);
    tests_run++;
    if (bus.cmpl_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release got %b want 0", bus.cmpl_valid);
    end
    wait_cmpl(q0 + 2, 100, ok);
    tests_run++;
    if (!ok || cq[q0 + 1] !== 9'h001) begin
      tests_failed++;
      $display("FAIL bp_second got %0d entries want tag 1", cq.size() - q0);
    end
  endtask

  task automatic test_reset_mid();
    int q0, e0;
    bit ok;
    do_reset();
    bus.cmpl_ready = 1'b1;
    mv_lat = 30;
    e0 = en_cnt;
    for (int k = 0; k < 3; k++) begin
      drive_desc(64'h40 * 64'(k), 64'h9000, 64'h40);
      wait_accept(20, ok);
    end
    bus.desc_valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    tests_run++;
    if (pending !== 3'd2 || bus.mover_done !== 1'b0 || en_cnt - e0 !== 1)
    begin
      tests_failed++;
      $display("FAIL rm_pre got pend=%0d done=%b en=%0d want 2 0 1",
               pending, bus.mover_done, en_cnt - e0);
    end
    areset = 1'b1;
    @(posedge aclk); #1;
    tests_run++;
    if ({pending, busy, bus.cmpl_valid, bus.mover_en} !== 6'b000_000) begin
      tests_failed++;
      $display("FAIL rm_post got pend=%0d busy=%b cv=%b en=%b want 0 0 0 0",
               pending, busy, bus.cmpl_valid, bus.mover_en);
    end
    areset = 1'b0;
    for (int i = 0; i < 100 && !mv_done_r; i++) @(posedge aclk);
    @(posedge aclk); #1;
    mv_lat = 3;
    q0 = cq.size();
    drive_desc(64'h5000, 64'h6000, 64'h40);
    wait_accept(20, ok);
    bus.desc_valid = 1'b0;
    wait_cmpl(q0 + 1, 100, ok);
    tests_run++;
    if (!ok || cq[q0] !== 9'h000) begin
      tests_failed++;
      $display("FAIL rm_tag got ok=%b want tag 0", ok);
    end
  endtask

  task automatic test_tag_wrap();
    int q0, e0, s0, d0;
    bit ok;
    do_reset();
    bus.cmpl_ready = 1'b1;
    mv_lat = 1;
    q0 = cq.size();
    e0 = en_cnt;
    s0 = stab_err;
    d0 = en_dbl;
    for (int k = 0; k < 257; k++) begin
      drive_desc(64'h10000 + (64'(k) << 8), 64'h80000 + (64'(k) << 8),
                 64'h40 + 64'h8 * 64'(k % 16));
      wait_accept(50, ok);
      if (!ok) begin
        tests_run++;
        tests_failed++;
        $display("FAIL wrap_accept%0d got timeout want accept", k);
        break;
      end
    end
    bus.desc_valid = 1'b0;
    wait_cmpl(q0 + 257, 5000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wrap_timeout got %0d want 257", cq.size() - q0);
    end else begin
      for (int k = 0; k < 257; k++) begin
        tests_run++;
        if (cq[q0 + k] !== {1'b0, 8'(k % 256)}) begin
          tests_failed++;
          $display("FAIL wrap_tag%0d got %h want %h",
                   k, cq[q0 + k], {1'b0, 8'(k % 256)});
        end
      end
    end
    tests_run += 3;
    if (stab_err !== s0) begin
      tests_failed++;
      $display("FAIL wrap_stability got %0d changes want 0", stab_err - s0);
    end
    if (en_dbl !== d0) begin
      tests_failed++;
      $display("FAIL wrap_en_width got %0d long pulses want 0", en_dbl - d0);
    end
    if (en_cnt - e0 !== 257) begin
      tests_failed++;
      $display("FAIL wrap_en_count got %0d want 257", en_cnt - e0);
    end
  endtask

  initial begin
    bus.desc_valid = 1'b0;
    bus.desc_src   = '0;
    bus.desc_dest  = '0;
    bus.desc_len   = '0;
    bus.cmpl_ready = 1'b0;
    test_reset();
    test_single();
    test_fifo_fill();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_tag_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
